uart_tx_serializer: RTL

UART transmitter that sits directly downstream of the UART/ALU interface block. It takes that block's tx-start request and its 8-bit ALU result, then shifts the frame onto the serial line: 1 start bit, DATA_BITS data bits LSB first, then the stop bit(s). It returns o_tx_active and o_tx_done to the interface block, which sequences its own state machine from them. Bit timing comes from an external baud generator that supplies a one-clock i_tick pulse at 16x the baud rate.

---
 rtl/uart_tx_serializer_if.sv | 27 ++
 rtl/uart_tx_serializer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer_if.sv
// Byte-in / serial-out handshake between the UART/ALU interface block and the
// transmit serializer.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_tx_start;
    logic [DATA_BITS-1:0] i_data;
    logic                 o_tx;
    logic                 o_tx_active;
    logic                 o_tx_done;

    modport master (
        output i_tx_start,
        output i_data,
        input  o_tx,
        input  o_tx_active,
        input  o_tx_done
    );

    modport slave (
        input  i_tx_start,
        input  i_data,
        output o_tx,
        output o_tx_active,
        output o_tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, SB_TICK ticks of stop,
// paced by a 16x oversampling baud tick. All outputs are registered.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int SB_TICK    = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tick,
    uart_tx_serializer_if.slave  tx_if
);
    localparam int S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int N_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t               state_r,  state_nxt_s;
    logic [S_W-1:0]       s_r,      s_nxt_s;
    logic [N_W-1:0]       n_r,      n_nxt_s;
    logic [DATA_BITS-1:0] shift_r,  shift_nxt_s;
    logic                 tx_r,     tx_nxt_s;
    logic                 active_r, active_nxt_s;
    logic                 done_r,   done_nxt_s;

    // Next-state, counter and shift-register logic; outputs are derived from the next state.
    always_comb begin
        state_nxt_s = state_r;
        s_nxt_s     = s_r;
        n_nxt_s     = n_r;
        shift_nxt_s = shift_r;
        done_nxt_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (tx_if.i_tx_start) begin
                    state_nxt_s = ST_START;
                    s_nxt_s     = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (i_tick && (s_r == S_BIT_LAST)) begin
                    // Byte is captured late so upstream can present it after seeing o_tx_active.
                    state_nxt_s = ST_DATA;
                    s_nxt_s     = '0;
                    n_nxt_s     = '0;
                    shift_nxt_s = tx_if.i_data;
                end else if (i_tick) begin
                    s_nxt_s = s_r + S_W'(1);
                end else begin
                    s_nxt_s = s_r;
                end
            end
            ST_DATA: begin
                if (i_tick && (s_r == S_BIT_LAST)) begin
                    s_nxt_s     = '0;
                    shift_nxt_s = shift_r >> 1;
                    if (n_r == N_LAST) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        n_nxt_s = n_r + N_W'(1);
                    end
                end else if (i_tick) begin
                    s_nxt_s = s_r + S_W'(1);
                end else begin
                    s_nxt_s = s_r;
                end
            end
            ST_STOP: begin
                if (i_tick && (s_r == S_STOP_LAST)) begin
                    state_nxt_s = ST_IDLE;
                    s_nxt_s     = '0;
                    done_nxt_s  = 1'b1;
                end else if (i_tick) begin
                    s_nxt_s = s_r + S_W'(1);
                end else begin
                    s_nxt_s = s_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                s_nxt_s     = '0;
                n_nxt_s     = '0;
            end
        endcase

        active_nxt_s = (state_nxt_s != ST_IDLE);
        case (state_nxt_s)
            ST_START: tx_nxt_s = 1'b0;
            ST_DATA:  tx_nxt_s = shift_nxt_s[0];
            default:  tx_nxt_s = 1'b1;
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r  <= ST_IDLE;
            s_r      <= '0;
            n_r      <= '0;
            shift_r  <= '0;
            tx_r     <= 1'b1;
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            s_r      <= s_nxt_s;
            n_r      <= n_nxt_s;
            shift_r  <= shift_nxt_s;
            tx_r     <= tx_nxt_s;
            active_r <= active_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    assign tx_if.o_tx        = tx_r;
    assign tx_if.o_tx_active = active_r;
    assign tx_if.o_tx_done   = done_r;
endmodule
